// File: rtl/scc_isa_pkg.sv
// Shared SCC ISA definitions used by the fetch unit and the instruction decoder.
// Holds the opcode constants, the canonical NOP encoding, instruction field
// positions, the fetch FSM state enum and the next-PC select enum.
package scc_isa_pkg;

  localparam logic [6:0] OP_B     = 7'b1100000;
  localparam logic [6:0] OP_BCOND = 7'b1100001;
  localparam logic [6:0] OP_BR    = 7'b1100010;
  localparam logic [6:0] OP_NOP   = 7'b1100100;
  localparam logic [6:0] OP_HALT  = 7'b1101000;

  localparam logic [31:0] NOP_WORD = 32'hC800_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 25;
  localparam int RA_MSB  = 24;
  localparam int RA_LSB  = 22;
  localparam int OFF_MSB = 15;
  localparam int OFF_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_KEEP = 2'd0,
    NPC_INC  = 2'd1,
    NPC_B    = 2'd2,
    NPC_BR   = 2'd3
  } npc_sel_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch -> decode instruction handshake.
//   inst       : instruction word
//   inst_pc    : PC of inst
//   inst_valid : inst holds a valid instruction
//   inst_ready : decoder accepts inst
// master = fetch unit (producer), slave = decoder (consumer).
interface fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output inst,
    output inst_pc,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  inst,
    input  inst_pc,
    input  inst_valid,
    output inst_ready
  );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select for the fetch unit.
//   pc             : current PC
//   sel            : keep / increment / B target / BR target
//   b_offset       : 16-bit signed B displacement
//   br_target      : register value for BR
//   redirect_valid : execute-stage redirect, overrides sel
//   redirect_pc    : redirect target
//   next_pc        : selected PC; all arithmetic wraps modulo 2^ADDR_W
module fetch_next_pc
  import scc_isa_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  npc_sel_e          sel,
  input  logic [15:0]       b_offset,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] off_ext;

  // sign-extend (or truncate) the displacement to the PC width
  assign off_ext = ADDR_W'(signed'(b_offset));

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else begin
      case (sel)
        NPC_INC: next_pc = pc + ADDR_W'(1);
        NPC_B:   next_pc = pc + off_ext;
        NPC_BR:  next_pc = br_target;
        default: next_pc = pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the single-issue SCC core.
// Reads instruction memory (1-cycle latency), resolves B/BR locally, stops on
// HALT and accepts execute-stage redirects. Feeds the decoder over fetch_unit_if.
//   clk, rst       : core clock, async active-high reset
//   imem_req/addr  : instruction memory read strobe / word address
//   imem_rdata     : read data, valid one cycle after imem_req
//   br_rd_addr/data: register-file read port used by BR
//   redirect_*     : PC redirect from execute
//   dec            : instruction handshake to the decoder (master side)
//   halted         : sticky HALT indication
//   fetch_count    : accepted-instruction count, present only when
//                    FETCH_PERF_CNT_EN is defined, otherwise tied to 0
//
// state     | meaning
// ----------+---------------------------------------------------
// FETCH     | issue imem read at pc
// WAIT      | decode response: B/BR/HALT handled here, others -> HOLD
// HOLD      | present inst to decoder until inst_ready
// HALTED    | absorbing; only rst exits
module fetch_unit
  import scc_isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [2:0]        br_rd_addr,
  input  logic [31:0]       br_rd_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      dec,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_valid_q;
  logic              halted_q;
  npc_sel_e          sel;
  logic              capture;
  logic              set_halt;
  logic              redirect_take;
  logic              accept;
  logic [6:0]        opcode;
  logic              unused_br_bits;

  assign opcode         = opcode_of(imem_rdata);
  assign redirect_take  = redirect_valid && (state != ST_HALTED);
  assign accept         = inst_valid_q && dec.inst_ready;
  assign unused_br_bits = ^br_rd_data[31:ADDR_W];

  always_comb begin
    state_next = state;
    sel        = NPC_KEEP;
    capture    = 1'b0;
    set_halt   = 1'b0;
    imem_req   = 1'b0;
    br_rd_addr = 3'd0;
    case (state)
      ST_FETCH: begin
        // FETCH is the reset state; keep the strobe quiet while rst is held
        imem_req   = !rst;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        br_rd_addr = imem_rdata[RA_MSB:RA_LSB];
        case (opcode)
          OP_B: begin
            sel        = NPC_B;
            state_next = ST_FETCH;
          end
          OP_BR: begin
            sel        = NPC_BR;
            state_next = ST_FETCH;
          end
          OP_HALT: begin
            set_halt   = 1'b1;
            state_next = ST_HALTED;
          end
          default: begin
            capture    = 1'b1;
            sel        = NPC_INC;
            state_next = ST_HOLD;
          end
        endcase
      end
      ST_HOLD: begin
        if (dec.inst_ready) state_next = ST_FETCH;
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: state_next = ST_FETCH;
    endcase
    // redirect discards whatever the current state was doing
    if (redirect_take) begin
      state_next = ST_FETCH;
      capture    = 1'b0;
      set_halt   = 1'b0;
    end
  end

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc             (pc),
    .sel            (sel),
    .b_offset       (imem_rdata[OFF_MSB:OFF_LSB]),
    .br_target      (br_rd_data[ADDR_W-1:0]),
    .redirect_valid (redirect_take),
    .redirect_pc    (redirect_pc),
    .next_pc        (pc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      inst_q       <= NOP_WORD;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (capture) begin
        inst_q    <= imem_rdata;
        inst_pc_q <= pc;
      end
      if (capture) begin
        inst_valid_q <= 1'b1;
      end else if (redirect_take || accept) begin
        inst_valid_q <= 1'b0;
      end
      if (set_halt) halted_q <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'd0;
`endif

  assign imem_addr      = pc;
  assign dec.inst       = inst_q;
  assign dec.inst_pc    = inst_pc_q;
  assign dec.inst_valid = inst_valid_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [6:0] T_B    = 7'b1100000;
  localparam logic [6:0] T_BR   = 7'b1100010;
  localparam logic [6:0] T_HALT = 7'b1101000;
  localparam logic [6:0] T_NOP  = 7'b1100100;
  localparam logic [31:0] T_NOP_WORD = 32'hC800_0000;

  localparam int M_REQ  = 0;
  localparam int M_RESP = 1;
  localparam int M_SHOW = 2;
  localparam int M_STOP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [2:0]  br_rd_addr;
  logic [31:0] br_rd_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;
  logic [31:0] fetch_count;

  fetch_unit_if #(.ADDR_W(16)) ifc ();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .br_rd_addr     (br_rd_addr),
    .br_rd_data     (br_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (ifc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic [31:0] rf  [0:7];

  assign br_rd_data = rf[br_rd_addr];

  // memory returns data exactly one cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
    else          imem_rdata <= $urandom;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int          m_phase;
  logic [15:0] m_pc;
  logic [31:0] m_inst;
  logic [15:0] m_inst_pc;
  logic        m_valid;
  logic        m_halted;
  logic [31:0] m_count;

  task automatic model_reset();
    m_phase   = M_REQ;
    m_pc      = 16'h0000;
    m_inst    = T_NOP_WORD;
    m_inst_pc = 16'h0000;
    m_valid   = 1'b0;
    m_halted  = 1'b0;
    m_count   = 32'd0;
  endtask

  task automatic model_advance();
    logic [31:0] w;
    int t;
    if (m_valid && ifc.inst_ready) begin
`ifdef FETCH_PERF_CNT_EN
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
`endif
    end
    if (m_phase != M_STOP && redirect_valid) begin
      m_pc    = redirect_pc;
      m_valid = 1'b0;
      m_phase = M_REQ;
    end else begin
      case (m_phase)
        M_REQ: m_phase = M_RESP;
        M_RESP: begin
          w = mem[m_pc];
          if (w[31:25] == T_B) begin
            t = int'(m_pc) + int'($signed(w[15:0]));
            m_pc = t[15:0];
            m_phase = M_REQ;
          end else if (w[31:25] == T_BR) begin
            m_pc = rf[w[24:22]][15:0];
            m_phase = M_REQ;
          end else if (w[31:25] == T_HALT) begin
            m_halted = 1'b1;
            m_phase = M_STOP;
          end else begin
            m_inst    = w;
            m_inst_pc = m_pc;
            m_valid   = 1'b1;
            t = int'(m_pc) + 1;
            m_pc = t[15:0];
            m_phase = M_SHOW;
          end
        end
        M_SHOW: begin
          if (ifc.inst_ready) begin
            m_valid = 1'b0;
            m_phase = M_REQ;
          end
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int   req_addr_q[$];
  int   req_cyc_q[$];
  int   acc_pc_q[$];
  logic [31:0] acc_inst_q[$];
  int   acc_cyc_q[$];
  logic br6_seen;

  always @(negedge clk) begin
    logic exp_req;
    logic [2:0] exp_bra;
    exp_req = (m_phase == M_REQ) && !rst;
    exp_bra = (m_phase == M_RESP && !rst) ? mem[m_pc][24:22] : 3'd0;
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
    check("br_rd_addr", {29'd0, br_rd_addr}, {29'd0, exp_bra});
    check("inst_valid", {31'd0, ifc.inst_valid}, {31'd0, m_valid});
    check("inst", ifc.inst, m_inst);
    check("inst_pc", {16'd0, ifc.inst_pc}, {16'd0, m_inst_pc});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("fetch_count", fetch_count, m_count);
    if (imem_req) begin
      req_addr_q.push_back(int'(imem_addr));
      req_cyc_q.push_back(cyc);
    end
    if (ifc.inst_valid && ifc.inst_ready) begin
      acc_pc_q.push_back(int'(ifc.inst_pc));
      acc_inst_q.push_back(ifc.inst);
      acc_cyc_q.push_back(cyc);
    end
    if (br_rd_addr == 3'd6) br6_seen = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic rdy, input logic rv, input logic [15:0] rpc);
    ifc.inst_ready = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    if (!rst) model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_cyc_q.delete();
    acc_pc_q.delete();
    acc_inst_q.delete();
    acc_cyc_q.delete();
    br6_seen = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    int r;
    logic [31:0] w;
    logic [6:0] op;
    int off;
    r = $urandom_range(99);
    w = $urandom;
    if (r < 2) begin
      w[31:25] = T_HALT;
    end else if (r < 10) begin
      w = T_NOP_WORD;
    end else if (r < 22) begin
      off = int'($urandom_range(16)) - 8;
      w[31:25] = T_B;
      w[15:0]  = off[15:0];
    end else if (r < 32) begin
      w[31:25] = T_BR;
    end else begin
      op = 7'($urandom);
      while (op == T_B || op == T_BR || op == T_HALT) op = 7'($urandom);
      w[31:25] = op;
    end
    return w;
  endfunction

  int n0;

  initial begin
    rst = 1'b1;
    model_reset();
    ifc.inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    br6_seen       = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = T_NOP_WORD;
    for (int i = 0; i < 8; i++) rf[i] = 32'd0;
    mem[0]    = {7'b0000001, 25'h0000123};
    mem[1]    = {7'b0000010, 25'h0000456};
    mem[2]    = T_NOP_WORD;
    mem[3]    = {T_BR, 3'd6, 22'd0};
    mem[5]    = {T_B, 9'd0, 16'hFFFD};
    mem[7]    = {T_HALT, 25'd0};
    mem[16'h20] = {7'b0000011, 25'h0000020};
    mem[16'h40] = {T_B, 9'd0, 16'hFFC5};
    rf[6]     = 32'h0000_0040;

    // A: straight-line, BR and B resolution, throughput
    do_reset();
    check("reset_inst", ifc.inst, T_NOP_WORD);
    check("reset_halted", {31'd0, halted}, 32'd0);
    clear_logs();
    repeat (30) tick(1'b1, 1'b0, 16'h0);
    check("A_req0", req_addr_q.size() > 6 ? req_addr_q[0] : -1, 0);
    check("A_req1", req_addr_q.size() > 6 ? req_addr_q[1] : -1, 1);
    check("A_req3", req_addr_q.size() > 6 ? req_addr_q[3] : -1, 3);
    check("A_br_target", req_addr_q.size() > 6 ? req_addr_q[4] : -1, 32'h40);
    check("A_b_fwd", req_addr_q.size() > 6 ? req_addr_q[5] : -1, 5);
    check("A_b_back", req_addr_q.size() > 6 ? req_addr_q[6] : -1, 2);
    check("A_br6_seen", {31'd0, br6_seen}, 32'd1);
    check("A_acc_pc1", acc_pc_q.size() > 3 ? acc_pc_q[1] : -1, 1);
    check("A_acc_pc2", acc_pc_q.size() > 3 ? acc_pc_q[2] : -1, 2);
    check("A_acc_pc3", acc_pc_q.size() > 3 ? acc_pc_q[3] : -1, 2);
    check("A_nop_inst", acc_inst_q.size() > 3 ? acc_inst_q[2] : 32'd0, T_NOP_WORD);
    check("A_latency", acc_cyc_q.size() > 1 ? acc_cyc_q[0] - req_cyc_q[0] : -1, 2);
    check("A_period", acc_cyc_q.size() > 1 ? acc_cyc_q[1] - acc_cyc_q[0] : -1, 3);
    n0 = 0;
    foreach (acc_pc_q[i]) if (acc_pc_q[i] == 5 || acc_pc_q[i] == 3 || acc_pc_q[i] == 32'h40) n0++;
    check("A_branch_hidden", n0, 0);

    // B: HOLD with inst_ready low for 4 cycles
    do_reset();
    clear_logs();
    repeat (6) tick(1'b0, 1'b0, 16'h0);
    check("B_hold_reqs", req_addr_q.size(), 1);
    check("B_hold_inst", ifc.inst, {7'b0000001, 25'h0000123});
    repeat (3) tick(1'b1, 1'b0, 16'h0);
    check("B_next_fetch", req_addr_q.size() == 2 ? req_addr_q[1] : -1, 1);

    // C: redirect during WAIT
    do_reset();
    clear_logs();
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h0020);
    tick(1'b1, 1'b0, 16'h0);
    check("C_no_valid", {31'd0, ifc.inst_valid}, 32'd0);
    check("C_redirect_addr", req_addr_q.size() == 2 ? req_addr_q[1] : -1, 32'h20);
    check("C_no_accept", acc_pc_q.size(), 0);

    // D: HALT at pc 7, redirect ignored, reset recovers
    do_reset();
    clear_logs();
    tick(1'b1, 1'b1, 16'h0007);
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    n0 = req_addr_q.size();
    for (int i = 0; i < 8; i++) tick(1'b1, i[0], 16'h0030);
    check("D_halted", {31'd0, halted}, 32'd1);
    check("D_no_req", req_addr_q.size() - n0, 0);
    do_reset();
    check("D_halt_cleared", {31'd0, halted}, 32'd0);
    tick(1'b1, 1'b0, 16'h0);
    check("D_refetch", req_addr_q.size() > 0 ? req_addr_q[req_addr_q.size()-1] : -1, 0);

    // randomized episodes against the model
    for (int ep = 0; ep < 3; ep++) begin
      for (int i = 0; i < 65536; i++) mem[i] = rand_word();
      for (int i = 0; i < 8; i++) rf[i] = $urandom;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
        if ((m_halted && $urandom_range(15) == 0) || $urandom_range(499) == 0)
          do_reset();
        else
          tick($urandom_range(9) < 7, $urandom_range(39) == 0, 16'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
